// File: rtl/lectura_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lectura_pkg
// Purpose  : Shared types and helpers for the lectura_operandos front-end:
//            operand-reader FSM states, tick period and counter widths.
// Revision : 1.0 - initial release
// ============================================================================
package lectura_pkg;

  // Reader FSM states
  typedef enum logic [2:0] {
    ST_WAIT_REL = 3'd0,
    ST_IDLE     = 3'd1,
    ST_COUNT    = 3'd2,
    ST_PEND     = 3'd3,
    ST_HELD     = 3'd4
  } estado_t;

  // Debounce stability counter width (DEB_MS is limited to 1..15)
  localparam int DEB_CNT_W = 4;

  // Number of clock cycles in one 1 ms tick period
  function automatic int tick_cyc(input int clk_hz);
    return clk_hz / 1000;
  endfunction

  // Bits needed to hold the values 0..max_val
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_canal.sv
`default_nettype none
// ============================================================================
// Module   : debounce_canal
// Purpose  : One debounce channel: two-flop synchroniser, per-tick stability
//            counter and the accepted (debounced) level. A new level is
//            accepted once it has differed from the current one on DEB_MS
//            consecutive ticks and still differs on the following tick.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_canal
  import lectura_pkg::*;
#(
  parameter int DEB_MS = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic raw_i,
  output logic deb_o
);

  logic                 sync1_q, sync2_q;
  logic                 deb_q, deb_d;
  logic [DEB_CNT_W-1:0] cnt_q, cnt_d;

  // Stability counting is evaluated only on the shared 1 ms tick
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (tick_i) begin
      if (sync2_q != deb_q) begin
        if (cnt_q == DEB_CNT_W'(DEB_MS)) begin
          deb_d = sync2_q;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + DEB_CNT_W'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  // Synchroniser, accepted level and stability counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule
`default_nettype wire

// File: rtl/lectura_operandos.sv
`default_nettype none
// ============================================================================
// Module   : lectura_operandos
// Purpose  : Booth multiplier input front-end. Debounces both operand switch
//            banks and the start button off one shared 1 ms tick, issues a
//            start after a HOLD_MS long press and presents a frozen operand
//            pair over a valid/ready handshake.
// Options  : LECTURA_REPEAT_EN - while the button stays held after an
//            accepted transfer, re-latch and re-issue every REPEAT_MS.
// Revision : 1.0 - initial release
// ============================================================================
module lectura_operandos
  import lectura_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int WIDTH     = 8,
  parameter int DEB_MS    = 4,
  parameter int HOLD_MS   = 500,
  parameter int REPEAT_MS = 250
) (
  input  logic               CLK100MHZ,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               pb_entrada,
  input  logic               op_ready,
  output logic               op_valid,
  output logic [WIDTH-1:0]   multiplicador,
  output logic [WIDTH-1:0]   multiplicando,
  output logic [2*WIDTH-1:0] LED,
  output logic               LED_pb
);

  localparam int TICK_CYC = tick_cyc(CLK_HZ);
  localparam int TICK_W   = cnt_w(TICK_CYC - 1);
  localparam int NCH      = 2 * WIDTH + 1;
  // The hold counter also times the repeat interval and the release
  // qualification after reset, so it is sized for the largest of the three.
  localparam int REL_TICKS = DEB_MS + 1;
  localparam int MAX_HR    = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
  localparam int HOLD_MAX  = (MAX_HR > REL_TICKS) ? MAX_HR : REL_TICKS;
  localparam int HOLD_W    = cnt_w(HOLD_MAX);

  logic              rst_meta_q, rst_sync_q;
  logic              rst_n_int;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;
  logic [NCH-1:0]    raw_all, deb_all;
  logic              pb_deb;
  estado_t           state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [WIDTH-1:0]  mplr_q, mplr_d, mpld_q, mpld_d;

  // Reset asserts asynchronously and is released synchronously
  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  assign rst_n_int = rst_sync_q;

  // Free-running 1 ms tick divider, tick on the last count
  always_comb begin
    tick       = (tick_cnt_q == TICK_W'(TICK_CYC - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
  end

  // Tick divider register
  always_ff @(posedge CLK100MHZ or negedge rst_n_int) begin
    if (!rst_n_int) tick_cnt_q <= '0;
    else            tick_cnt_q <= tick_cnt_d;
  end

  assign raw_all = {pb_entrada, A, B};

  for (genvar i = 0; i < NCH; i++) begin : g_canal
    debounce_canal #(
      .DEB_MS (DEB_MS)
    ) u_canal (
      .clk_i  (CLK100MHZ),
      .rst_ni (rst_n_int),
      .tick_i (tick),
      .raw_i  (raw_all[i]),
      .deb_o  (deb_all[i])
    );
  end

  assign pb_deb = deb_all[NCH-1];
  assign LED    = deb_all[2*WIDTH-1:0];
  assign LED_pb = pb_deb;

  // Reader FSM next state, hold counting and operand latch
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    mplr_d  = mplr_q;
    mpld_d  = mpld_q;
    case (state_q)
      // The debounced button starts at 0 after reset even if it is held, so
      // release is only trusted once it has read 0 on more ticks than a
      // debounced rise can take.
      ST_WAIT_REL: begin
        if (tick) begin
          if (pb_deb) begin
            hold_d = '0;
          end else if (hold_q == HOLD_W'(REL_TICKS)) begin
            state_d = ST_IDLE;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end
      ST_IDLE: begin
        hold_d = '0;
        if (pb_deb) state_d = ST_COUNT;
      end
      ST_COUNT: begin
        if (!pb_deb) begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end else if (tick) begin
          if (hold_q == HOLD_W'(HOLD_MS - 1)) begin
            state_d = ST_PEND;
            hold_d  = '0;
            mplr_d  = deb_all[2*WIDTH-1:WIDTH];
            mpld_d  = deb_all[WIDTH-1:0];
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end
      ST_PEND: begin
        if (op_ready) begin
          state_d = pb_deb ? ST_HELD : ST_IDLE;
          hold_d  = '0;
        end
      end
      ST_HELD: begin
        if (!pb_deb) begin
          state_d = ST_IDLE;
          hold_d  = '0;
`ifdef LECTURA_REPEAT_EN
        end else if (tick) begin
          if (hold_q == HOLD_W'(REPEAT_MS - 1)) begin
            state_d = ST_PEND;
            hold_d  = '0;
            mplr_d  = deb_all[2*WIDTH-1:WIDTH];
            mpld_d  = deb_all[WIDTH-1:0];
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
`endif
        end
      end
      default: begin
        state_d = ST_WAIT_REL;
        hold_d  = '0;
      end
    endcase
  end

  // FSM state, hold counter and latched operand registers
  always_ff @(posedge CLK100MHZ or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q <= ST_WAIT_REL;
      hold_q  <= '0;
      mplr_q  <= '0;
      mpld_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      mplr_q  <= mplr_d;
      mpld_q  <= mpld_d;
    end
  end

  assign op_valid      = (state_q == ST_PEND);
  assign multiplicador = mplr_q;
  assign multiplicando = mpld_q;

endmodule
`default_nettype wire

// File: tb/tb_lectura_operandos.sv
`default_nettype none
// ============================================================================
// Module   : tb_lectura_operandos
// Purpose  : Directed self-checking bench for lectura_operandos with a 10
//            cycle tick (CLK_HZ=10_000), DEB_MS=3, HOLD_MS=5, REPEAT_MS=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lectura_operandos;

  localparam int TICK = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  a = 8'h00;
  logic [7:0]  b = 8'h00;
  logic        pb = 1'b0;
  logic        rdy = 1'b1;
  logic        op_valid;
  logic [7:0]  mplr, mpld;
  logic [15:0] led;
  logic        led_pb;

  int total = 0;
  int bad   = 0;
  int ok, n, cnt, exp_rep;

  always #5 clk = ~clk;

  lectura_operandos #(
    .CLK_HZ    (10_000),
    .WIDTH     (8),
    .DEB_MS    (3),
    .HOLD_MS   (5),
    .REPEAT_MS (4)
  ) dut (
    .CLK100MHZ     (clk),
    .reset_n       (rst_n),
    .A             (a),
    .B             (b),
    .pb_entrada    (pb),
    .op_ready      (rdy),
    .op_valid      (op_valid),
    .multiplicador (mplr),
    .multiplicando (mpld),
    .LED           (led),
    .LED_pb        (led_pb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int k);
    repeat (k * TICK) @(negedge clk);
  endtask

  // Waits for LED_pb to reach lvl, up to 100 cycles
  task automatic wait_pb(input logic lvl, output int found);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (led_pb === lvl) begin
        found = 1;
        break;
      end
    end
  endtask

  // Cycles until op_valid is seen, or -1 if not within lim cycles
  task automatic wait_valid(input int lim, output int cyc);
    cyc = -1;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      if (op_valid === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
`ifdef LECTURA_REPEAT_EN
    exp_rep = 4;
`else
    exp_rep = 1;
`endif
    // Reset state with live inputs applied
    a = 8'hA5;
    repeat (3) @(negedge clk);
    chk("rst_valid", op_valid, 0);
    chk("rst_mplr", mplr, 0);
    chk("rst_mpld", mpld, 0);
    chk("rst_led", led, 0);
    chk("rst_ledpb", led_pb, 0);
    rst_n = 1'b1;
    ticks(8);
    chk("deb_a5", led[15:8], 8'hA5);

    // One-tick glitch is rejected
    a = 8'h00;
    repeat (TICK) @(negedge clk);
    a = 8'hA5;
    chk("glitch_mid", led[15:8], 8'hA5);
    ticks(6);
    chk("glitch_after", led[15:8], 8'hA5);

    // Steady new value is accepted, not too early
    a = 8'h3C;
    repeat (15) @(negedge clk);
    chk("steady_early", led[15:8], 8'hA5);
    ticks(5);
    chk("steady_3c", led[15:8], 8'h3C);

    // Normal long press with ready high
    a = 8'h12;
    b = 8'hF3;
    ticks(6);
    chk("led_ab", led, 16'h12F3);
    pb = 1'b1;
    wait_pb(1'b1, ok);
    chk("pb_rise", ok, 1);
    wait_valid(80, n);
    chk("start_lat", n, 50);
    chk("start_mplr", mplr, 8'h12);
    chk("start_mpld", mpld, 8'hF3);
    @(negedge clk);
    chk("pulse_1cyc", op_valid, 0);
    pb = 1'b0;
    wait_pb(1'b0, ok);
    chk("pb_fall", ok, 1);
    ticks(8);

    // Short press does not issue
    pb = 1'b1;
    wait_pb(1'b1, ok);
    pb = 1'b0;
    wait_valid(120, n);
    chk("short_none", n, -1);
    chk("short_rel", led_pb, 0);

    // Back-pressure keeps operands frozen, release ignored while pending
    rdy = 1'b0;
    pb  = 1'b1;
    wait_pb(1'b1, ok);
    wait_valid(80, n);
    chk("bp_lat", n, 50);
    chk("bp_mplr0", mplr, 8'h12);
    a  = 8'h77;
    pb = 1'b0;
    ticks(8);
    chk("bp_valid", op_valid, 1);
    chk("bp_mplr", mplr, 8'h12);
    chk("bp_led", led[15:8], 8'h77);
    chk("bp_ledpb", led_pb, 0);
    rdy = 1'b1;
    @(negedge clk);
    chk("bp_drop", op_valid, 0);
    ticks(2);

    // Button held across reset: no issue until release and re-press
    pb = 1'b1;
    wait_pb(1'b1, ok);
    rst_n = 1'b0;
    #1;
    chk("rst2_valid", op_valid, 0);
    chk("rst2_mplr", mplr, 0);
    chk("rst2_mpld", mpld, 0);
    chk("rst2_led", led, 0);
    chk("rst2_ledpb", led_pb, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_valid(150, n);
    chk("rst_hold_none", n, -1);
    pb = 1'b0;
    ticks(14);
    pb = 1'b1;
    wait_pb(1'b1, ok);
    wait_valid(80, n);
    chk("repress_lat", n, 50);
    chk("repress_mplr", mplr, 8'h77);
    chk("repress_mpld", mpld, 8'hF3);
    pb = 1'b0;
    wait_pb(1'b0, ok);
    ticks(2);

    // Long hold: one issue, or repeats every 4 ticks after acceptance
    pb = 1'b1;
    wait_pb(1'b1, ok);
    cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (op_valid === 1'b1) cnt++;
    end
    chk("repeat_cnt", cnt, exp_rep);
    pb = 1'b0;
    wait_pb(1'b0, ok);
    ticks(10);
    chk("end_idle", op_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
